// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the RAM arbiter and boot sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } boot_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

    localparam int unsigned DEFAULT_RELEASE_CYCLES = 4;
    localparam int unsigned REL_CNT_W              = 8;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_boot_seq.sv
// ============================================================================
// Module   : mem_arb_boot_seq
// Brief    : Boot sequencer; holds the core in reset through image load and a
//            fixed settle window before letting it run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_boot_seq
    import mem_arb_pkg::*;
#(
    parameter int unsigned RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_en_i,
    input  logic        boot_done_i,
    output logic        cpu_rst_o,
    output boot_state_e state_o
);

    localparam logic [REL_CNT_W-1:0] REL_LAST = REL_CNT_W'(RELEASE_CYCLES - 1);

    boot_state_e          state_q, state_d;
    logic [REL_CNT_W-1:0] rel_cnt_q, rel_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RESET;
            rel_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rel_cnt_d = '0;
        cpu_rst_o = 1'b1;
        case (state_q)
            ST_RESET:   state_d = boot_en_i ? ST_LOAD : ST_RELEASE;
            ST_LOAD: begin
                if (boot_done_i) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rel_cnt_q == REL_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + 8'd1;
                end
            end
            ST_RUN:     cpu_rst_o = 1'b0;
            default:    state_d = ST_RESET;
        endcase
    end

    assign state_o = state_q;

endmodule : mem_arb_boot_seq

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares a single-port synchronous RAM between the core (always
//            wins) and a DMA/boot-loader master; routes read data back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_en,
    input  logic              boot_done,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rstrb,
    input  logic [3:0]        cpu_wstrb,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [3:0]        dma_wstrb,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rstrb,
    output logic [3:0]        m_wstrb,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic [CNT_W-1:0]  dma_grant_cnt,
    output logic [1:0]        state_o
);

    boot_state_e      boot_state;
    owner_e           owner_q, owner_d;
    logic             rd_pend_q;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic             core_active;
    logic             dma_phase;

    mem_arb_boot_seq #(
        .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_boot_seq (
        .clk         (clk),
        .rst         (rst),
        .boot_en_i   (boot_en),
        .boot_done_i (boot_done),
        .cpu_rst_o   (cpu_rst),
        .state_o     (boot_state)
    );

    assign core_active = cpu_rstrb | (|cpu_wstrb);
    // The loader may use the RAM throughout LOAD and RELEASE; only RUN lets the core in.
    assign dma_phase   = (boot_state == ST_LOAD) || (boot_state == ST_RELEASE);

    always_comb begin
        m_addr      = cpu_addr;
        m_rstrb     = 1'b0;
        m_wstrb     = 4'b0000;
        m_wdata     = cpu_wdata;
        dma_gnt     = 1'b0;
        owner_d     = OWN_CORE;
        grant_cnt_d = grant_cnt_q;
        if ((boot_state == ST_RUN) && core_active) begin
            m_rstrb = cpu_rstrb;
            m_wstrb = cpu_wstrb;
        end else if (((boot_state == ST_RUN) || dma_phase) && dma_req) begin
            dma_gnt = 1'b1;
            m_addr  = dma_addr;
            m_rstrb = ~dma_we;
            m_wstrb = dma_we ? dma_wstrb : 4'b0000;
            m_wdata = dma_wdata;
            owner_d = OWN_DMA;
        end
        if (dma_gnt && (grant_cnt_q != {CNT_W{1'b1}})) begin
            grant_cnt_d = grant_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q     <= OWN_CORE;
            rd_pend_q   <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            owner_q     <= owner_d;
            rd_pend_q   <= m_rstrb;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    // RAM data lands one cycle after the strobe; steer it to whoever issued it.
    assign dma_rvalid    = rd_pend_q && (owner_q == OWN_DMA);
    assign dma_rdata     = dma_rvalid ? m_rdata : 32'h0;
    assign cpu_rdata     = dma_rvalid ? 32'h0 : m_rdata;
    assign dma_grant_cnt = grant_cnt_q;
    assign state_o       = boot_state;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter with a queue-based read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, boot_en, boot_done, cpu_rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rstrb;
    logic [3:0]  cpu_wstrb;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic        m_rstrb;
    logic [3:0]  m_wstrb;
    logic [15:0] dma_grant_cnt;
    logic [1:0]  state_o;

    mem_arbiter #(
        .ADDR_W         (32),
        .RELEASE_CYCLES (4),
        .CNT_W          (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .boot_en       (boot_en),
        .boot_done     (boot_done),
        .cpu_rst       (cpu_rst),
        .cpu_addr      (cpu_addr),
        .cpu_rstrb     (cpu_rstrb),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .dma_req       (dma_req),
        .dma_we        (dma_we),
        .dma_addr      (dma_addr),
        .dma_wstrb     (dma_wstrb),
        .dma_wdata     (dma_wdata),
        .dma_gnt       (dma_gnt),
        .dma_rvalid    (dma_rvalid),
        .dma_rdata     (dma_rdata),
        .m_addr        (m_addr),
        .m_rstrb       (m_rstrb),
        .m_wstrb       (m_wstrb),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .dma_grant_cnt (dma_grant_cnt),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, one-cycle read latency.
    bit [31:0] mem [0:63];
    always @(posedge clk) begin
        if (m_rstrb) m_rdata <= mem[m_addr[7:2]];
        for (int b = 0; b < 4; b++) begin
            if (m_wstrb[b]) mem[m_addr[7:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t dma_q[$];
    exp_t cpu_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   rel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (dma_rvalid) begin
                if (dma_q.size() == 0) begin
                    chk("dma_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = dma_q.pop_front();
                    chk("dma_rvalid_cycle", cyc, e.cyc);
                    chk("dma_rdata", dma_rdata, e.data);
                end
            end else if (dma_q.size() > 0 && dma_q[0].cyc <= cyc) begin
                e = dma_q.pop_front();
                chk("dma_rvalid_missing", 32'd0, 32'd1);
            end
            if (cpu_q.size() > 0 && cpu_q[0].cyc <= cyc) begin
                e = cpu_q.pop_front();
                chk("cpu_rdata_cycle", cyc, e.cyc);
                chk("cpu_rdata", cpu_rdata, e.data);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dma_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = a; dma_wdata = d; dma_wstrb = s;
        #1;
        chk("dma_gnt_wr", {31'd0, dma_gnt}, 32'd1);
        chk("m_wstrb_dma", {28'd0, m_wstrb}, {28'd0, s});
        step();
        dma_req = 1'b0;
    endtask

    task automatic dma_rd(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = a;
        #1;
        chk("dma_gnt_rd", {31'd0, dma_gnt}, 32'd1);
        e.cyc = cyc + 1; e.data = d;
        dma_q.push_back(e);
        step();
        dma_req = 1'b0;
    endtask

    task automatic cpu_rd(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        cpu_rstrb = 1'b1; cpu_addr = a;
        e.cyc = cyc + 1; e.data = d;
        cpu_q.push_back(e);
        step();
        cpu_rstrb = 1'b0;
    endtask

    task automatic count_release();
        rel = 0;
        while (state_o == 2'd2 && rel < 20) begin
            chk("cpu_rst_release", {31'd0, cpu_rst}, 32'd1);
            rel++;
            step();
        end
        chk("release_cycles", rel, 32'd4);
        chk("state_run", {30'd0, state_o}, 32'd3);
        chk("cpu_rst_run", {31'd0, cpu_rst}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b0; boot_en = 1'b1; boot_done = 1'b0;
        cpu_addr = '0; cpu_rstrb = 1'b0; cpu_wstrb = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wstrb = '0; dma_wdata = '0;
        fork
            monitor_loop();
        join_none

        // Reset state
        step(); step();
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        chk("rst_grant_cnt", {16'd0, dma_grant_cnt}, 32'd0);
        chk("rst_m_strobes", {27'd0, m_rstrb, m_wstrb}, 32'd0);

        // Boot path: load image while the core is held in reset
        rst = 1'b1;
        step();
        chk("load_state", {30'd0, state_o}, 32'd1);
        chk("load_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        cpu_rstrb = 1'b1; cpu_wstrb = 4'hF;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h10; dma_wdata = 32'hDEADBEEF; dma_wstrb = 4'hF;
        #1;
        chk("load_m_addr", m_addr, 32'h10);
        chk("load_m_wdata", m_wdata, 32'hDEADBEEF);
        dma_wr(32'h10, 32'hDEADBEEF, 4'hF);
        cpu_rstrb = 1'b0; cpu_wstrb = 4'h0;
        dma_wr(32'h20, 32'h11112222, 4'hF);
        dma_wr(32'h24, 32'h33334444, 4'hF);
        dma_wr(32'h30, 32'hAABBCCDD, 4'hF);
        boot_done = 1'b1;
        dma_rd(32'h10, 32'hDEADBEEF);
        boot_done = 1'b0;
        count_release();
        chk("ram_0x10", mem[4], 32'hDEADBEEF);
        chk("grant_cnt_boot", {16'd0, dma_grant_cnt}, 32'd5);

        // Collision: core read wins, DMA waits one cycle
        cpu_rstrb = 1'b1; cpu_addr = 32'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        #1;
        chk("coll_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("coll_m_addr", m_addr, 32'h0);
        chk("coll_m_rstrb", {31'd0, m_rstrb}, 32'd1);
        e.cyc = cyc + 1; e.data = 32'h0;
        cpu_q.push_back(e);
        step();
        cpu_rstrb = 1'b0;

        // Routing: DMA read at N, core read at N+1
        dma_rd(32'h20, 32'h11112222);
        cpu_rd(32'h24, 32'h33334444);
        chk("route_rvalid_n2", {31'd0, dma_rvalid}, 32'd0);

        // RUN ignores boot controls
        boot_done = 1'b1; boot_en = 1'b1;
        step();
        boot_done = 1'b0;
        chk("run_sticky", {30'd0, state_o}, 32'd3);

        // Reset during LOAD with a DMA read in flight
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("reload_state", {30'd0, state_o}, 32'd1);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        #1;
        chk("midrst_gnt", {31'd0, dma_gnt}, 32'd1);
        rst = 1'b0;
        step();
        dma_req = 1'b0;
        chk("midrst_state", {30'd0, state_o}, 32'd0);
        chk("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("midrst_grant_cnt", {16'd0, dma_grant_cnt}, 32'd0);
        chk("midrst_rvalid", {31'd0, dma_rvalid}, 32'd0);
        step();

        // No-boot path
        boot_en = 1'b0; rst = 1'b1;
        step();
        chk("noboot_state", {30'd0, state_o}, 32'd2);
        count_release();

        // Statistics and byte-masked DMA writes
        dma_wr(32'h30, 32'h00550000, 4'b0100);
        dma_wr(32'h30, 32'h00660000, 4'b0100);
        dma_wr(32'h30, 32'h00770000, 4'b0100);
        chk("stat_grant_cnt", {16'd0, dma_grant_cnt}, 32'd3);
        chk("ram_0x30", mem[12], 32'hAA77CCDD);
        cpu_rd(32'h30, 32'hAA77CCDD);

        step(); step(); step();
        chk("dma_q_drained", dma_q.size(), 32'd0);
        chk("cpu_q_drained", cpu_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire
